// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: fetch-PC sequencer, 1-cycle-latency memory port and a PC-tagged FIFO to decode.
// Optional same-cycle bypass of a response into an empty buffer is enabled by defining PREFETCH_BYPASS_EN.
module prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_address,
  output logic                     imem_enable,
  input  logic [31:0]              imem_data,
  input  logic                     imem_wait,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  output logic [31:0]              out_instruction,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic empty;
  logic accept;
  logic bypass;
  logic push;
  logic pop;

  // Request gating, output selection and FIFO push/pop decisions.
  always_comb begin
    empty       = (count == '0);
    imem_enable = !reset && !redirect_valid &&
                  (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
    accept      = imem_enable && !imem_wait;
`ifdef PREFETCH_BYPASS_EN
    bypass      = empty && inflight;
`else
    bypass      = 1'b0;
`endif
    out_valid       = !reset && !redirect_valid && (!empty || bypass);
    out_instruction = 32'h0;
    out_pc          = 32'h0;
    if (!empty) begin
      out_instruction = mem_instr[rd_ptr];
      out_pc          = mem_pc[rd_ptr];
    end else if (bypass) begin
      out_instruction = imem_data;
      out_pc          = inflight_pc;
    end
    pop  = out_valid && out_ready && !empty;
    // A bypassed word that decode takes this cycle never enters the FIFO.
    push = inflight && !redirect_valid && !(bypass && out_ready);
  end

  assign imem_address = fetch_pc;
  assign occupancy    = count;

  // Control state; redirect overrides every same-cycle push, pop and request.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      inflight <= accept;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Datapath storage: request tag and FIFO payload, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      inflight_pc <= fetch_pc;
    end
    if (push && !reset) begin
      mem_instr[wr_ptr] <= imem_data;
      mem_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed table-driven bench for prefetch_buffer (DEPTH=4, RESET_PC=0, bypass disabled).
module tb_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic        imem_enable;
  logic [31:0] imem_data;
  logic        imem_wait;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_address(imem_address), .imem_enable(imem_enable),
    .imem_data(imem_data), .imem_wait(imem_wait),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instruction(out_instruction), .out_pc(out_pc),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_F00D;
  endfunction

  // Memory model: answers an accepted request on the following cycle.
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_a = 32'h0;
  always @(posedge clk) begin
    rsp_v <= imem_enable && !imem_wait;
    rsp_a <= imem_address;
  end
  assign imem_data = rsp_v ? word_at(rsp_a) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        wt;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] opc;
    logic [2:0]  occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic wt, input logic rd,
                              input logic [31:0] rpc, input logic rdy,
                              input logic en, input logic [31:0] addr,
                              input logic ov, input logic [31:0] opc,
                              input logic [2:0] occ);
    vec_t v;
    v.rst = rst; v.wt = wt; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.en = en; v.addr = addr; v.ov = ov; v.opc = opc; v.occ = occ;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h required %h", name, idx, act, exp);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; imem_wait = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b1;

    // rst wt rd rpc rdy | en addr ov opc occ
    vecs.push_back(mk(1,0,0,0,1, 0,32'h0, 0,32'h0,0));  // reset cycle
    vecs.push_back(mk(0,0,0,0,1, 1,32'h0, 0,32'h0,0));  // first request at RESET_PC
    vecs.push_back(mk(0,0,0,0,1, 1,32'h4, 0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h8, 1,32'h0,1));  // first out_valid in cycle 2
    vecs.push_back(mk(0,0,0,0,1, 1,32'hC, 1,32'h4,1));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h10,1,32'h8,1));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h14,1,32'hC,1));  // imem_wait for 3 cycles
    vecs.push_back(mk(0,1,0,0,1, 1,32'h14,1,32'h10,1));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h14,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h14,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h18,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h1C,1,32'h14,1));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h20,1,32'h18,1));  // decode stalls, buffer fills
    vecs.push_back(mk(0,0,0,0,0, 1,32'h24,1,32'h18,2));
    vecs.push_back(mk(0,0,0,0,0, 0,32'h28,1,32'h18,3));
    vecs.push_back(mk(0,0,0,0,0, 0,32'h28,1,32'h18,4));
    vecs.push_back(mk(0,0,0,0,0, 0,32'h28,1,32'h18,4));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h28,1,32'h18,4));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h28,1,32'h1C,3));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h2C,1,32'h1C,3));  // pop and push together
    vecs.push_back(mk(0,0,0,0,0, 1,32'h2C,1,32'h20,3));
    vecs.push_back(mk(0,0,0,0,0, 0,32'h30,1,32'h20,3));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h30,1,32'h20,4));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h30,1,32'h24,3));
    vecs.push_back(mk(0,0,1,32'h100,0, 0,32'h34,0,32'h24,3)); // redirect, 3 buffered + 1 in flight
    vecs.push_back(mk(0,0,0,0,1, 1,32'h100,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h104,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h108,1,32'h100,1));
    vecs.push_back(mk(0,0,1,32'hFFFF_FFF8,1, 0,32'h10C,0,32'h104,1));
    vecs.push_back(mk(0,0,0,0,1, 1,32'hFFFF_FFF8,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'hFFFF_FFFC,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h0,1,32'hFFFF_FFF8,1));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h4,1,32'hFFFF_FFFC,1));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h8,1,32'h0,1));
    vecs.push_back(mk(1,0,0,0,1, 0,32'hC,0,32'h4,1));   // reset mid-fetch
    vecs.push_back(mk(0,0,0,0,1, 1,32'h0,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h4,0,32'h0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h8,1,32'h0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst; imem_wait = vecs[i].wt; redirect_valid = vecs[i].rd;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      @(negedge clk);
      chk("imem_enable", i, 32'(imem_enable), 32'(vecs[i].en));
      chk("imem_address", i, imem_address, vecs[i].addr);
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
      chk("out_pc", i, out_pc, vecs[i].opc);
      chk("occupancy", i, 32'(occupancy), 32'(vecs[i].occ));
      if (vecs[i].ov) chk("out_instruction", i, out_instruction, word_at(vecs[i].opc));
    end

    // Latency from reset release to first out_valid, bounded.
    @(posedge clk); #1;
    reset = 1'b1; imem_wait = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid_cycle", 100, 32'(n), 32'd2);
    chk("first_out_pc", 100, out_pc, 32'h0);
    chk("first_out_instruction", 100, out_instruction, word_at(32'h0));

    // Empty buffer presents zeros during a redirect flush.
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_out_pc_zero", 101, out_pc, 32'h0);
    chk("flush_out_instr_zero", 101, out_instruction, 32'h0);
    chk("flush_address", 101, imem_address, 32'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
